// File: rtl/dxy_pkg.sv
// Shared types and constants for the SPU displacement-term sequencer.
// Holds the FSM state encoding and the constant used by both multiplier and adder.
package dxy_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      MUL_AA  = 3'd1,
      MUL_B2  = 3'd2,
      MUL_RES = 3'd3,
      DONE    = 3'd4
   } dxy_state_t;

   localparam int unsigned TWO = 2;

endpackage

// File: rtl/mul.sv
// Unsigned N-bit multiplier, product truncated to the low N bits.
// Latency: combinational; backpressure: none.
module mul #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] p
);

   assign p = a * b;

endmodule

// File: rtl/sumador.sv
// Unsigned N-bit adder with carry in and carry out.
// Latency: combinational; backpressure: none.
module sumador #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] s,
   output logic         cout
);

   assign {cout, s} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/dxy_seq.sv
// Sequencer for res = a*a*(1 - 2*bx) mod 2^N using one shared multiplier over three cycles.
// Latency: out_valid rises 3 edges after accept; backpressure: result held in DONE until out_ready.
module dxy_seq
   import dxy_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] bx,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] res,
   output logic         busy
);

   dxy_state_t   state;
   logic [N-1:0] a_q;
   logic [N-1:0] bx_q;
   logic [N-1:0] aa_q;
   logic [N-1:0] term_q;
   logic [N-1:0] mul_x;
   logic [N-1:0] mul_y;
   logic [N-1:0] prod;
   logic [N-1:0] term_d;
   logic         add_cout_unused;

   // Operand steering follows the state; idle states feed zeros so the multiplier stays quiet.
   always_comb begin
      mul_x = '0;
      mul_y = '0;
      case (state)
         MUL_AA: begin
            mul_x = a_q;
            mul_y = a_q;
         end
         MUL_B2: begin
            mul_x = bx_q;
            mul_y = N'(TWO);
         end
         MUL_RES: begin
            mul_x = aa_q;
            mul_y = term_q;
         end
         default: ;
      endcase
   end

   mul #(.N(N)) u_mul (
      .a (mul_x),
      .b (mul_y),
      .p (prod)
   );

   // 2 + ~(2*bx) is the two's-complement form of 1 - 2*bx.
   sumador #(.N(N)) u_add (
      .a    (N'(TWO)),
      .b    (~prod),
      .cin  (1'b0),
      .s    (term_d),
      .cout (add_cout_unused)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         res       <= '0;
         a_q       <= '0;
         bx_q      <= '0;
         aa_q      <= '0;
         term_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q      <= a;
                  bx_q     <= bx;
                  state    <= MUL_AA;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            MUL_AA: begin
               aa_q  <= prod;
               state <= MUL_B2;
            end
            MUL_B2: begin
               term_q <= term_d;
               state  <= MUL_RES;
            end
            MUL_RES: begin
               res       <= prod;
               state     <= DONE;
               out_valid <= 1'b1;
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/dxy_seq.md
# dxy_seq

Multi-cycle sequencer for the SPU displacement term res = a·a·(1 − 2·BX), computed mod 2^N. One shared `mul #(N)` instance handles the three products across three cycles, replacing three parallel multipliers. Sits between the SPU shape-control logic (requester) and the result path, with valid/ready handshakes on both sides.

## Interface

**Parameters**
- N, 8, operand and result width in bits; all arithmetic is unsigned two's-complement mod 2^N.

**Ports**
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  request: a and bx are valid.
- in_ready  out  1  block can accept a request.
- a  in  N  operand a.
- bx  in  N  operand BX.
- out_valid  out  1  res holds a completed result.
- out_ready  in  1  consumer accepts res.
- res  out  N  result a·a·(1 − 2·BX) mod 2^N.
- busy  out  1  high in every state except IDLE.

## Operation

- States: IDLE, MUL_AA, MUL_B2, MUL_RES, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid, latch a into a_q and bx into bx_q, then go to MUL_AA.
- MUL_AA: multiplier operands (a_q, a_q); store product into aa_q; go to MUL_B2.
- MUL_B2:
  - Multiplier operands (bx_q, 2).
  - Store term_q = 2 + ~product mod 2^N, which equals 1 − 2·bx_q.
  - Go to MUL_RES.
- MUL_RES: multiplier operands (aa_q, term_q); store product into res; go to DONE.
- DONE:
  - out_valid = 1 and res is held stable.
  - On out_ready, go to IDLE.
  - With out_ready low, stay in DONE indefinitely.
- in_ready is 1 only in IDLE. in_valid in any other state is ignored and nothing is latched.
- Multiplier operand mux is driven by state. In IDLE and DONE its operands are 0.
- All products are truncated to the low N bits. No saturation and no overflow flag.

## Timing

- Reset values: state = IDLE; in_ready = 1; out_valid = 0; busy = 0; res = 0; a_q, bx_q, aa_q, term_q all 0.
- Reset asserted in any state, including mid-computation or in DONE with a result pending:
  - Next edge forces the reset values.
  - The in-flight result is discarded.
- Latency:
  - Request accepted at edge E0 (in_valid & in_ready).
  - out_valid rises after edge E0+3.
  - The earliest next accept is the edge after the out handshake, so throughput is one result per ≥5 cycles.
- in_valid high in DONE while out_ready is high: the DONE→IDLE transition occurs. The request is accepted only on a later edge in IDLE.
- res changes only on the MUL_RES edge and on reset.

## Structure

- Shared package `dxy_pkg`:
  - State enum `dxy_state_t` (IDLE, MUL_AA, MUL_B2, MUL_RES, DONE).
  - Constant TWO = 2 used as a multiplier operand and an adder operand.
- One sub-module instance: the existing `mul #(N)` as the single shared multiplier.
- The 2 + ~x step uses the existing `sumador #(N)` with carry-in 0; its carry-out is left unused.
- FSM, operand mux and registers live in dxy_seq itself.

## Test plan

All scenarios use N = 8.

- a=3, bx=2, out_ready=1 -> out_valid after 3 cycles, res=229 (9·(−3) mod 256); busy high for 4 cycles.
- a=5, bx=0 -> res=25; a=0, bx=77 -> res=0.
- Wrap cases:
  - a=16, bx=1 -> res=0 (aa overflows to 0).
  - a=3, bx=128 -> res=9 (2·bx wraps to 0, term=1).
- Backpressure: a=3, bx=2 with out_ready low for 6 cycles -> out_valid stays 1, res stays 229, in_ready stays 0, and a second in_valid is ignored. out_ready=1 -> IDLE next edge.
- rst_n low for 1 cycle while in MUL_B2 -> next edge: state IDLE, res=0, out_valid=0, in_ready=1. The following request a=5, bx=0 -> res=25.
- Back-to-back requests with in_valid held high and out_ready=1 -> second accept occurs exactly 5 edges after the first; results arrive in order.
